ejector_sink: RTL and testbench

//  Traffic sink at a router's Local output port, the receive end of the injector Req/Gnt/Full protocol.

---
 rtl/ejector_sink.sv | 189 ++++++++++++++++++
 tb/tb_ejector_sink.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ejector_sink.sv
// Receive end of the Req/Gnt/Full injector handshake: buffers packets in a small FIFO,
// drains them at a fixed rate and checks destination and PacketID sequence on every pop.
module ejector_sink #(
  parameter int               dataWidth   = 32,
  parameter int               dim         = 4,
  parameter logic [dim-1:0]   X_ID        = 4'b1_010,
  parameter logic [dim-1:0]   Y_ID        = 4'b1_100,
  parameter int               DEPTH       = 4,
  parameter int               DRAIN_DELAY = 2,
  parameter int               CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqUpStr,
  input  logic [dataWidth-1:0] PacketIn,
  output logic                 GntUpStr,
  output logic                 UpStrFull,
  output logic                 RxValid,
  output logic [dataWidth-1:0] RxPacket,
  output logic [CNT_W-1:0]     RxCount,
  output logic [CNT_W-1:0]     DstErrCount,
  output logic [CNT_W-1:0]     SeqErrCount
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int DW    = (DRAIN_DELAY > 0) ? $clog2(DRAIN_DELAY + 1) : 1;
  localparam int ID_HI = 15;
  localparam int ID_LO = 6;
  localparam int ID_W  = ID_HI - ID_LO + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_C = DW'(DRAIN_DELAY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_gnt;
  logic                   w_gnt_next;

  logic [dataWidth-1:0]   r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [DW-1:0]          r_drain;

  logic                   r_rx_valid;
  logic [dataWidth-1:0]   r_rx_packet;
  logic [CNT_W-1:0]       r_rx_count;
  logic [CNT_W-1:0]       r_dst_err;
  logic [CNT_W-1:0]       r_seq_err;
  logic [ID_W-1:0]        r_exp_id;

  logic                   w_push;
  logic                   w_pop;
  logic [dataWidth-1:0]   w_head;
  logic [ID_W-1:0]        w_head_id;
  logic                   w_dst_err;
  logic                   w_seq_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != {CNT_W{1'b1}})) begin
      r = v + CNT_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Push only from IDLE on the pre-edge count, so a same-edge pop never opens room at full.
  assign w_push    = (r_state == S_IDLE) && ReqUpStr && (r_count < DEPTH_C);
  assign w_pop     = (r_count != {CW{1'b0}}) && (r_drain == DRAIN_C);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_id = w_head[ID_HI:ID_LO];
  assign w_dst_err = (w_head[dataWidth-1 -: dim] != X_ID) ||
                     (w_head[dataWidth-dim-1 -: dim] != Y_ID);
  assign w_seq_err = (w_head_id != r_exp_id);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= w_gnt_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_gnt_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_push) begin
          w_next_state = S_GRANT;
          w_gnt_next   = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_GRANT: begin
        w_next_state = S_DROP;
      end
      S_DROP: begin
        // Wait for upstream to drop Req so one request is never captured twice.
        if (!ReqUpStr) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DROP;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= PacketIn;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pacing counter: idles at zero while empty, restarts after every pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drain <= {DW{1'b0}};
    end else if ((r_count == {CW{1'b0}}) || w_pop) begin
      r_drain <= {DW{1'b0}};
    end else begin
      r_drain <= r_drain + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_valid  <= 1'b0;
      r_rx_packet <= {dataWidth{1'b0}};
      r_rx_count  <= {CNT_W{1'b0}};
      r_dst_err   <= {CNT_W{1'b0}};
      r_seq_err   <= {CNT_W{1'b0}};
      r_exp_id    <= ID_W'(1);
    end else begin
      r_rx_valid <= w_pop;
      if (w_pop) begin
        r_rx_packet <= w_head;
        r_rx_count  <= sat_inc(r_rx_count, 1'b1);
        r_dst_err   <= sat_inc(r_dst_err, w_dst_err);
        r_seq_err   <= sat_inc(r_seq_err, w_seq_err);
        r_exp_id    <= w_head_id + ID_W'(1);
      end
    end
  end

  assign GntUpStr    = r_gnt;
  assign UpStrFull   = (r_count == DEPTH_C);
  assign RxValid     = r_rx_valid;
  assign RxPacket    = r_rx_packet;
  assign RxCount     = r_rx_count;
  assign DstErrCount = r_dst_err;
  assign SeqErrCount = r_seq_err;

endmodule

// File: tb/tb_ejector_sink.sv
// Bench for ejector_sink: two instances (drain delay 2 and 15) driven by an upstream model,
// with a transaction-level scoreboard for packet order, occupancy and error counters.
module tb_ejector_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] pkt [2];
  logic [1:0]  gnt, full, rxv;
  logic [31:0] rxp [2];
  logic [15:0] rxc [2];
  logic [15:0] dec [2];
  logic [15:0] sec [2];

  always #5 clk = ~clk;

  ejector_sink #(.DRAIN_DELAY(2)) u_fast (
    .clk(clk), .reset(reset), .ReqUpStr(req[0]), .PacketIn(pkt[0]),
    .GntUpStr(gnt[0]), .UpStrFull(full[0]), .RxValid(rxv[0]), .RxPacket(rxp[0]),
    .RxCount(rxc[0]), .DstErrCount(dec[0]), .SeqErrCount(sec[0])
  );

  ejector_sink #(.DRAIN_DELAY(15)) u_slow (
    .clk(clk), .reset(reset), .ReqUpStr(req[1]), .PacketIn(pkt[1]),
    .GntUpStr(gnt[1]), .UpStrFull(full[1]), .RxValid(rxv[1]), .RxPacket(rxp[1]),
    .RxCount(rxc[1]), .DstErrCount(dec[1]), .SeqErrCount(sec[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] exp_mem [2][4096];
  int n_push [2];
  int n_pop [2];
  int m_rx [2];
  int m_dst [2];
  int m_seq [2];
  int m_exp [2];
  int last_pop [2];
  int first_pop [2];
  int last_gnt [2];
  int dd [2] = '{2, 15};
  logic [1:0] prev_gnt;
  int next_id [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      n_push[d] = 0; n_pop[d] = 0;
      m_rx[d] = 0; m_dst[d] = 0; m_seq[d] = 0; m_exp[d] = 1;
      last_pop[d] = -1000; first_pop[d] = -1; last_gnt[d] = -1;
    end
    prev_gnt = 2'b00;
  endtask

  // One clock edge, then scoreboard both instances on the settled outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int occ_pre;
      logic [31:0] p;
      int id;
      occ_pre = n_push[d] - n_pop[d];
      check("gnt_pulse", 64'(gnt[d] & prev_gnt[d]), 64'd0);
      if (gnt[d]) begin
        check("gnt_req", 64'(req[d]), 64'd1);
        check("gnt_room", 64'(occ_pre < 4), 64'd1);
        exp_mem[d][n_push[d]] = pkt[d];
        n_push[d]++;
        last_gnt[d] = cyc;
      end
      if (rxv[d]) begin
        check("pop_nonempty", 64'(occ_pre > 0), 64'd1);
        if (occ_pre > 0) begin
          p = exp_mem[d][n_pop[d]];
          n_pop[d]++;
          check("rx_packet", 64'(rxp[d]), 64'(p));
          check("pop_spacing", 64'((cyc - last_pop[d]) >= dd[d] + 1), 64'd1);
          last_pop[d] = cyc;
          if (n_pop[d] == 1) first_pop[d] = cyc;
          id = int'(p[15:6]);
          m_rx[d] = sat16(m_rx[d] + 1);
          if (p[31:28] != 4'hA || p[27:24] != 4'hC) m_dst[d] = sat16(m_dst[d] + 1);
          if (id != m_exp[d]) m_seq[d] = sat16(m_seq[d] + 1);
          m_exp[d] = (id + 1) % 1024;
        end
      end
      check("full", 64'(full[d]), 64'((n_push[d] - n_pop[d]) == 4));
      check("rx_count", 64'(rxc[d]), 64'(m_rx[d]));
      check("dst_err_count", 64'(dec[d]), 64'(m_dst[d]));
      check("seq_err_count", 64'(sec[d]), 64'(m_seq[d]));
      prev_gnt[d] = gnt[d];
    end
  endtask

  // Upstream model: hold Req until Gnt, keep it through the edge that samples Gnt, then drop.
  task automatic send(input int d, input logic [31:0] p);
    int k;
    req[d] = 1'b1;
    pkt[d] = p;
    k = 0;
    do begin
      tick();
      k++;
    end while (!gnt[d] && k < 300);
    check("gnt_timeout", 64'(gnt[d]), 64'd1);
    tick();
    check("gnt_one_cycle", 64'(gnt[d]), 64'd0);
    req[d] = 1'b0;
    tick();
  endtask

  task automatic wait_pop(input int d, input int n);
    int k;
    k = 0;
    while (n_pop[d] < n && k < 600) begin
      tick();
      k++;
    end
    check("pop_timeout", 64'(n_pop[d] >= n), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = 2'b00;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] xd, input logic [3:0] yd, input int id);
    return {xd, yd, 8'h00, 10'(id), 6'd0};
  endfunction

  initial begin
    int k;
    logic [3:0] xd;
    int id;
    int d;
    reset = 1'b0;
    req = 2'b00;
    pkt[0] = 32'd0;
    pkt[1] = 32'd0;
    model_reset();
    repeat (3) tick();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_rxv", 64'(rxv), 64'd0);
    for (int i = 0; i < 2; i++) begin
      check("rst_rxcount", 64'(rxc[i]), 64'd0);
      check("rst_dst", 64'(dec[i]), 64'd0);
      check("rst_seq", 64'(sec[i]), 64'd0);
      check("rst_packet", 64'(rxp[i]), 64'd0);
    end
    reset = 1'b1;

    // Single packet latency on the fast instance
    send(0, 32'hAC00_0040);
    wait_pop(0, 1);
    check("t2_latency", 64'(last_pop[0] - last_gnt[0]), 64'd3);
    check("t2_packet", 64'(rxp[0]), 64'hAC00_0040);
    check("t2_rxcount", 64'(rxc[0]), 64'd1);
    check("t2_dst", 64'(dec[0]), 64'd0);
    check("t2_seq", 64'(sec[0]), 64'd0);
    tick();
    check("t2_rxv_pulse", 64'(rxv[0]), 64'd0);

    // Fill the slow instance; fifth grant must wait for the first pop
    for (int i = 1; i <= 4; i++) send(1, mk(4'hA, 4'hC, i));
    check("t3_full", 64'(full[1]), 64'd1);
    check("t3_no_pop_yet", 64'(n_pop[1]), 64'd0);
    send(1, mk(4'hA, 4'hC, 5));
    check("t3_fifth_after_pop", 64'(last_gnt[1]), 64'(first_pop[1] + 1));
    wait_pop(1, 5);
    check("t3_rxcount", 64'(rxc[1]), 64'd5);
    check("t3_seq", 64'(sec[1]), 64'd0);
    check("t3_last", 64'(rxp[1]), 64'(mk(4'hA, 4'hC, 5)));

    // Wrong destination
    send(0, mk(4'b0_011, 4'hC, 2));
    wait_pop(0, 2);
    check("t4_dst", 64'(dec[0]), 64'd1);
    check("t4_rxcount", 64'(rxc[0]), 64'd2);
    check("t4_seq", 64'(sec[0]), 64'd0);

    // Sequence gap and wrap
    do_reset();
    send(0, mk(4'hA, 4'hC, 1));
    send(0, mk(4'hA, 4'hC, 2));
    send(0, mk(4'hA, 4'hC, 4));
    wait_pop(0, 3);
    check("t5_gap", 64'(sec[0]), 64'd1);
    send(0, mk(4'hA, 4'hC, 5));
    wait_pop(0, 4);
    check("t5_resync", 64'(sec[0]), 64'd1);
    send(0, mk(4'hA, 4'hC, 1022));
    wait_pop(0, 5);
    check("t5_jump", 64'(sec[0]), 64'd2);
    send(0, mk(4'hA, 4'hC, 1023));
    send(0, mk(4'hA, 4'hC, 0));
    wait_pop(0, 7);
    check("t5_wrap", 64'(sec[0]), 64'd2);
    check("t5_rxcount", 64'(rxc[0]), 64'd7);

    // Reset with three queued entries and a grant in flight
    do_reset();
    for (int i = 1; i <= 3; i++) send(1, mk(4'hA, 4'hC, i));
    req[1] = 1'b1;
    pkt[1] = mk(4'hA, 4'hC, 4);
    k = 0;
    do begin
      tick();
      k++;
    end while (!gnt[1] && k < 100);
    check("t6_gnt_seen", 64'(gnt[1]), 64'd1);
    reset = 1'b0;
    model_reset();
    #1;
    check("t6_gnt_async", 64'(gnt[1]), 64'd0);
    check("t6_full_async", 64'(full[1]), 64'd0);
    req[1] = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (40) tick();
    check("t6_no_rx", 64'(rxc[1]), 64'd0);
    check("t6_no_rxv", 64'(rxv[1]), 64'd0);

    // Randomized traffic on both instances
    next_id[0] = 1;
    next_id[1] = 1;
    for (int i = 0; i < 80; i++) begin
      d = (i % 4 == 3) ? 1 : 0;
      id = ($urandom_range(7) == 0) ? int'($urandom_range(1023)) : next_id[d];
      next_id[d] = (id + 1) % 1024;
      xd = ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'hA;
      send(d, {xd, 4'hC, 8'($urandom), 10'(id), 6'($urandom)});
      repeat ($urandom_range(3)) tick();
    end
    wait_pop(0, n_push[0]);
    wait_pop(1, n_push[1]);
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
